// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and default sizes for the RAM access blocks
//                (stream reader, address wrap helper, planned write streamer).
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Default RAM geometry used by the RAM and the blocks that access it
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DEPTH_DEF      = 1024;

    // Read streamer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_addr_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : ram_addr_wrap
//  Description : Combinational next-address for a RAM of DEPTH words.
//                Increments the address and wraps to zero after DEPTH-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_addr_wrap
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);

    generate
        if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_natural_wrap
            // Full address space: the adder overflow already wraps to zero
            assign o_next_addr = i_addr + c_ONE;
        end else begin : g_explicit_wrap
            // Partial address space: wrap explicitly at the last valid word
            assign o_next_addr = (i_addr == c_LAST_ADDR) ? '0 : (i_addr + c_ONE);
        end
    endgenerate

endmodule : ram_addr_wrap
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_stream_reader
//  Description : Sweeps LENGTH consecutive RAM words from START_ADDR through
//                the asynchronous RAM read port and presents them as a
//                valid/ready stream with a last marker, then pulses done.
//                The read address doubles as the sweep pointer, so under
//                back-pressure the same word is simply re-read until the
//                output stage frees up.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam logic [ADDR_WIDTH:0] c_LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] c_LEN_ONE  = (ADDR_WIDTH+1)'(1);

    // Registered state
    rd_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_read_addr;
    logic                  r_read_enable;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;

    // Next-state values
    rd_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_read_addr_nxt;
    logic                  w_read_enable_nxt;
    logic [ADDR_WIDTH:0]   w_remaining_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [DATA_WIDTH-1:0] w_m_data_nxt;
    logic                  w_m_valid_nxt;
    logic                  w_m_last_nxt;

    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_can_load;

    // Output stage accepts a new word when empty or being emptied this cycle
    assign w_can_load = !r_m_valid || m_ready;

    ram_addr_wrap #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_wrap (
        .i_addr      (r_read_addr),
        .o_next_addr (w_addr_inc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        w_state_nxt       = r_state;
        w_read_addr_nxt   = r_read_addr;
        w_read_enable_nxt = r_read_enable;
        w_remaining_nxt   = r_remaining;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_m_data_nxt      = r_m_data;
        w_m_valid_nxt     = r_m_valid;
        w_m_last_nxt      = r_m_last;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length != c_LEN_ZERO) begin
                        w_read_addr_nxt = start_addr;
                        w_remaining_nxt = length;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = STREAM;
                    end else begin
                        // Empty transfer: acknowledge immediately, no beats
                        w_done_nxt = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (!r_read_enable) begin
                    // First stream cycle: the address is already set up
                    w_read_enable_nxt = 1'b1;
                end else if (w_can_load) begin
                    w_m_data_nxt    = read_data;
                    w_m_valid_nxt   = 1'b1;
                    w_m_last_nxt    = (r_remaining == c_LEN_ONE);
                    w_remaining_nxt = r_remaining - c_LEN_ONE;
                    w_read_addr_nxt = w_addr_inc;
                    if (r_remaining == c_LEN_ONE) begin
                        w_read_enable_nxt = 1'b0;
                        w_state_nxt       = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (r_m_valid && m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_m_last_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end

            default: begin
                w_state_nxt       = IDLE;
                w_read_enable_nxt = 1'b0;
                w_busy_nxt        = 1'b0;
                w_m_valid_nxt     = 1'b0;
                w_m_last_nxt      = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_read_addr   <= '0;
            r_read_enable <= 1'b0;
            r_remaining   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
        end else begin
            r_read_addr   <= w_read_addr_nxt;
            r_read_enable <= w_read_enable_nxt;
            r_remaining   <= w_remaining_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_m_data      <= w_m_data_nxt;
            r_m_valid     <= w_m_valid_nxt;
            r_m_last      <= w_m_last_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign read_addr   = r_read_addr;
    assign read_enable = r_read_enable;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;

endmodule : ram_stream_reader
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_stream_reader
//  Description : Directed testbench for ram_stream_reader with an async-read
//                RAM model preloaded with mem[i] = i (low 8 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int DP = 1024;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] read_addr;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] mem [0:DP-1];

    int checks;
    int errors;

    // Collector results
    logic [DW-1:0] beat_data [0:63];
    logic          beat_last [0:63];
    int            beat_cycle[0:63];
    logic [AW-1:0] ra_log    [0:63];
    int            beat_n;
    int            ra_n;
    int            done_cycle;
    int            done_count;
    int            hold_bad;
    int            busy_bad;
    logic          rp [0:31];
    int            rp_len;

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .read_addr   (read_addr),
        .read_enable (read_enable),
        .read_data   (read_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    assign read_data = read_enable ? mem[read_addr] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns just after the accepting edge (cycle 0)
    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] l);
        start      = 1'b1;
        start_addr = a;
        length     = l;
        tick();
        start = 1'b0;
    endtask

    // Watch the stream cycle by cycle until done or budget; records beats,
    // loaded read addresses, hold-stability and busy violations.
    task automatic collect(input int budget, input int inj_cycle);
        logic          have_hold;
        logic [DW-1:0] hold_data;
        logic          hold_last;
        beat_n = 0; ra_n = 0; done_cycle = -1; done_count = 0;
        hold_bad = 0; busy_bad = 0; have_hold = 1'b0;
        hold_data = '0; hold_last = 1'b0;
        for (int c = 0; c < budget; c++) begin
            m_ready = (c < rp_len) ? rp[c] : 1'b1;
            if (c == inj_cycle) begin
                start = 1'b1; start_addr = 10'd500; length = 11'd2;
            end else begin
                start = 1'b0;
            end
            if (have_hold && (!m_valid || m_data !== hold_data || m_last !== hold_last))
                hold_bad++;
            have_hold = 1'b0;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
            if (read_enable && (!m_valid || m_ready) && ra_n < 64) begin
                ra_log[ra_n] = read_addr;
                ra_n++;
            end
            if (m_valid && m_ready) begin
                if (beat_n < 64) begin
                    beat_data[beat_n]  = m_data;
                    beat_last[beat_n]  = m_last;
                    beat_cycle[beat_n] = c;
                end
                beat_n++;
            end else if (m_valid) begin
                have_hold = 1'b1; hold_data = m_data; hold_last = m_last;
            end
            if (done_cycle >= 0) break;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; start_addr = 10'd7; length = 11'd4; m_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, read_enable, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b re=%b valid=%b last=%b want all 0",
                     busy, done, read_enable, m_valid, m_last);
        end
        checks++;
        if (read_addr !== 10'd0 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got read_addr=%0d m_data=%0d want 0 0", read_addr, m_data);
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        rp_len = 0;
        do_start(10'd5, 11'd4);
        collect(40, -1);
        checks++;
        if (beat_n !== 4) begin
            errors++; $display("FAIL basic_count got %0d want 4", beat_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_data[i] !== 8'(5 + i) || beat_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_beat%0d got data=%0d last=%b want data=%0d last=%b",
                             i, beat_data[i], beat_last[i], 5 + i, (i == 3));
                end
            end
            checks++;
            if (beat_cycle[0] !== 2 || beat_cycle[3] !== 5) begin
                errors++;
                $display("FAIL basic_latency got first=%0d last=%0d want 2 5", beat_cycle[0], beat_cycle[3]);
            end
        end
        checks++;
        if (done_cycle !== 6 || busy_bad !== 0) begin
            errors++;
            $display("FAIL basic_done got done_cycle=%0d busy_bad=%0d want 6 0", done_cycle, busy_bad);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a [0:3];
        logic [DW-1:0] exp_d [0:3];
        exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
        exp_d[0] = 8'd254;   exp_d[1] = 8'd255;   exp_d[2] = 8'd0;  exp_d[3] = 8'd1;
        rp_len = 0;
        do_start(10'd1022, 11'd4);
        collect(40, -1);
        checks++;
        if (beat_n !== 4 || ra_n !== 4) begin
            errors++; $display("FAIL wrap_count got beats=%0d reads=%0d want 4 4", beat_n, ra_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ra_log[i] !== exp_a[i] || beat_data[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, ra_log[i], beat_data[i], exp_a[i], exp_d[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_pressure;
        // cycles 0,1 are setup; first valid at cycle 2 sees ready 1,0,0,1,0,1
        rp[0] = 1; rp[1] = 1; rp[2] = 1; rp[3] = 0; rp[4] = 0;
        rp[5] = 1; rp[6] = 0; rp[7] = 1;
        rp_len = 8;
        do_start(10'd0, 11'd3);
        collect(40, -1);
        rp_len = 0;
        checks++;
        if (beat_n !== 3) begin
            errors++; $display("FAIL bp_count got %0d want 3", beat_n);
        end else begin
            checks++;
            if (beat_data[0] !== 8'd0 || beat_data[1] !== 8'd1 || beat_data[2] !== 8'd2 ||
                beat_last[2] !== 1'b1 || beat_last[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_data got %0d %0d %0d last2=%b want 0 1 2 last2=1",
                         beat_data[0], beat_data[1], beat_data[2], beat_last[2]);
            end
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad);
        end
        checks++;
        if (done_cycle !== 8 || done_count !== 1) begin
            errors++;
            $display("FAIL bp_done got cycle=%0d count=%0d want 8 1", done_cycle, done_count);
        end
        tick();
    endtask

    task automatic test_zero_length;
        do_start(10'd3, 11'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || read_enable !== 1'b0) begin
            errors++;
            $display("FAIL zero_len got done=%b busy=%b valid=%b re=%b want 1 0 0 0",
                     done, busy, m_valid, read_enable);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after got done=%b busy=%b valid=%b want 0 0 0", done, busy, m_valid);
        end
    endtask

    task automatic test_start_while_busy;
        int bad;
        rp_len = 0;
        do_start(10'd100, 11'd6);
        collect(40, 3);
        checks++;
        if (beat_n !== 6 || done_count !== 1 || done_cycle !== 8) begin
            errors++;
            $display("FAIL busy_start_count got beats=%0d done=%0d at %0d want 6 1 8",
                     beat_n, done_count, done_cycle);
        end else begin
            bad = 0;
            for (int i = 0; i < 6; i++)
                if (beat_data[i] !== 8'(100 + i)) bad++;
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL busy_start_data got %0d wrong beats want 0", bad);
            end
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_valid || busy || read_enable) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL busy_start_queued got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        rp_len = 0;
        m_ready = 1'b1;
        do_start(10'd10, 11'd5);
        tick(); tick(); tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd11) begin
            errors++; $display("FAIL rmid_pre got valid=%b data=%0d want 1 11", m_valid, m_data);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({m_valid, read_enable, busy, done, m_last} !== 5'b0 || read_addr !== 10'd0) begin
            errors++;
            $display("FAIL rmid_reset got valid=%b re=%b busy=%b done=%b last=%b addr=%0d want 0",
                     m_valid, read_enable, busy, done, m_last, read_addr);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_no_done got done=%b valid=%b want 0 0", done, m_valid);
        end
        do_start(10'd20, 11'd3);
        collect(40, -1);
        checks++;
        if (beat_n !== 3 || done_count !== 1 || beat_data[0] !== 8'd20 ||
            beat_data[2] !== 8'd22 || beat_last[2] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_restart got beats=%0d done=%0d first=%0d third=%0d want 3 1 20 22",
                     beat_n, done_count, beat_data[0], beat_data[2]);
        end
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; rp_len = 0;
        for (int i = 0; i < DP; i++) mem[i] = 8'(i);
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_stream_reader
`default_nettype wire
